rtc_access_scheduler: RTL and testbench
=======================================

Name: rtc_access_scheduler

Overview:
Shares the single RTC bus engine (FSM_W_R plus its address/data muxes) between three transaction owners: initialization, user write (esc) and periodic read (lec). It grants the bus to one owner at a time for a fixed-length window and drives that owner's do_it. It also drives the mux select and inserts an idle gap between windows. It also generates the periodic read tick and blocks write/read until the first initialization has completed.

Parameters:
INIC_CYCLES, 422, length of init window in clk cycles (covers the full 12-register init sequence)
ESC_CYCLES, 422, length of write window
LEC_CYCLES, 422, length of read window
GAP_CYCLES, 8, idle cycles between windows, all do_it low
READ_PERIOD, 1000000, clk cycles between periodic read requests
POR_INIT, 1, 1 = init request pending automatically out of reset

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
req_inic  in  1  init request, level or pulse; sampled every cycle
req_esc  in  1  write request (user edit committed), pulse
en_lec  in  1  enables periodic reading
do_it_inic  out  1  runs the init FSM
do_it_esc  out  1  runs the write FSM
do_it_lec  out  1  runs the read FSM
sel_bus  out  2  bus mux select: 00 none, 01 inic, 10 esc, 11 lec
busy  out  1  high in any GRANT or GAP state
inic_done  out  1  1-cycle pulse at the end of an init window
esc_done  out  1  1-cycle pulse at the end of a write window
lec_done  out  1  1-cycle pulse at the end of a read window (read data valid to latch)
init_ok  out  1  sticky; set on the first inic_done

Behaviour:
- All outputs are registered. Reset values: do_it_* = 0, sel_bus = 00, busy = 0, *_done = 0, init_ok = 0, state = IDLE, pend_esc = 0, pend_lec = 0, pend_inic = POR_INIT, tick timer = 0.
- Pending flags: pend_x <= (pend_x & ~take_x) | req_x. A request arriving in the same cycle its pending flag is consumed re-arms the flag, giving a second transaction. Repeated requests while a flag is already pending merge into one.
- States: IDLE, G_INIC, G_ESC, G_LEC, GAP.
- IDLE transitions, by priority:
  - pend_inic -> G_INIC.
  - else, if init_ok: pend_esc -> G_ESC; else pend_lec -> G_LEC.
  - If init_ok = 0, esc and lec requests stay pending and are not granted.
- Grant latency: a pending flag visible in IDLE at edge N gives do_it_x = 1 and sel_bus = code from edge N+1.
- G_x: a window counter (9 bits minimum; size to the largest *_CYCLES) counts 0..X_CYCLES-1. do_it_x stays high for exactly X_CYCLES cycles, and sel_bus is held constant.
- Window end: do_it_x drops, x_done pulses for 1 cycle, and the state moves to GAP.
- GAP: GAP_CYCLES cycles with do_it_* = 0 and sel_bus = 00. Then IDLE. At most one do_it is high at any time, and there are always ≥ GAP_CYCLES zero cycles between windows.
- init_ok is set in the cycle inic_done is asserted and is cleared only by reset. A later req_inic re-runs init without clearing init_ok.
- Tick timer (counter width ceil(log2(READ_PERIOD))):
  - Counts while en_lec = 1.
  - At READ_PERIOD-1 it wraps to 0 and sets pend_lec.
  - A tick arriving while pend_lec is already set is lost (no queueing).
  - en_lec = 0 holds the timer at 0 and clears pend_lec. A read window already in progress completes.
- Simultaneous requests: in the same cycle, inic beats esc beats lec. Losers remain pending.
- Reset mid-window: next edge forces reset values; the window is aborted with no done pulse.
- Windows are never preempted; a higher-priority request waits for the current window plus its GAP.

Decomposition:
- Package rtc_sched_pkg holds:
  - the state encoding enum (IDLE, G_INIC, G_ESC, G_LEC, GAP);
  - the sel_bus code constants SEL_NONE, SEL_INIC, SEL_ESC, SEL_LEC;
  - the default window length 422.
- Sub-module rtc_tick_gen (READ_PERIOD parameter; inputs clk, reset, en; output 1-cycle tick) holds the periodic timer.

Test Plan:
1. Reset with POR_INIT=1, req_* = 0 -> do_it_inic rises 2 edges after reset release and stays high 422 cycles; sel_bus = 01; then inic_done pulses, init_ok = 1, and 8 gap cycles follow with sel_bus = 00.
2. POR_INIT=0; pulse req_esc and set en_lec=1 with READ_PERIOD=100, no init -> no grant for 1000 cycles. Then pulse req_inic -> init window runs, followed by the esc window after the gap; lec runs afterwards.
3. After init_ok, assert req_esc and a lec tick in the same cycle -> esc window of 422 cycles first, lec window after 8 gap cycles. do_it_esc and do_it_lec are never both high.
4. READ_PERIOD=100, LEC_CYCLES=422, en_lec=1 -> ticks during the read window merge into one pending flag, so reads run back to back separated by exactly 8 gap cycles. Then drop en_lec mid-window -> the window completes, lec_done pulses, and no further reads follow.
5. Assert reset at cycle 200 of an esc window -> the next edge shows do_it_esc = 0, sel_bus = 00, busy = 0, no esc_done, pending flags cleared.
6. Pulse req_esc 3 times during one init window -> exactly one esc window follows. A req_esc in the cycle pend_esc is consumed -> a second esc window follows.

Source files
------------

// File: rtl/rtc_sched_pkg.sv
// Shared types and constants for the RTC bus access scheduler.
// It holds the state encoding, the bus-select codes and the owner indices.
package rtc_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    G_INIC,
    G_ESC,
    G_LEC,
    GAP
  } sched_state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_INIC = 2'b01;
  localparam logic [1:0] SEL_ESC  = 2'b10;
  localparam logic [1:0] SEL_LEC  = 2'b11;

  localparam int DEFAULT_WINDOW = 422;
  localparam int DEFAULT_GAP    = 8;

  // Bit positions of each owner in the request/pending/do_it/done vectors
  localparam int NUM_OWNERS = 3;
  localparam int OWN_INIC   = 0;
  localparam int OWN_ESC    = 1;
  localparam int OWN_LEC    = 2;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [NUM_OWNERS-1:0] owner_mask(input sched_state_t s);
    case (s)
      G_INIC:  return 3'b001;
      G_ESC:   return 3'b010;
      G_LEC:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] sel_code(input sched_state_t s);
    case (s)
      G_INIC:  return SEL_INIC;
      G_ESC:   return SEL_ESC;
      G_LEC:   return SEL_LEC;
      default: return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rtc_tick_gen.sv
// Periodic read tick: one-cycle pulse every READ_PERIOD enabled cycles.
// Dropping en holds the timer at zero so the period restarts from scratch.
module rtc_tick_gen #(
  parameter int READ_PERIOD = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int TW = (READ_PERIOD > 1) ? $clog2(READ_PERIOD) : 1;
  localparam logic [TW-1:0] LAST = TW'(READ_PERIOD - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + TW'(1);
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/rtc_access_scheduler.sv
// Time-multiplexes the single RTC bus engine between init, user write and
// periodic read owners, with fixed-length windows separated by idle gaps.
module rtc_access_scheduler
  import rtc_sched_pkg::*;
#(
  parameter int INIC_CYCLES = DEFAULT_WINDOW,
  parameter int ESC_CYCLES  = DEFAULT_WINDOW,
  parameter int LEC_CYCLES  = DEFAULT_WINDOW,
  parameter int GAP_CYCLES  = DEFAULT_GAP,
  parameter int READ_PERIOD = 1000000,
  parameter bit POR_INIT    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_inic,
  input  logic       req_esc,
  input  logic       en_lec,
  output logic       do_it_inic,
  output logic       do_it_esc,
  output logic       do_it_lec,
  output logic [1:0] sel_bus,
  output logic       busy,
  output logic       inic_done,
  output logic       esc_done,
  output logic       lec_done,
  output logic       init_ok
);

  localparam int MAX_LEN = max_of(max_of(INIC_CYCLES, ESC_CYCLES),
                                  max_of(LEC_CYCLES, GAP_CYCLES));
  localparam int CW = max_of(9, $clog2(MAX_LEN + 1));
  // Arbitration happens on the last GAP cycle, so with the one-cycle grant
  // latency the next window starts exactly GAP_CYCLES idle cycles later.
  // GAP_CYCLES must therefore be at least 2.
  localparam logic [CW-1:0] GAP_ARB = CW'(GAP_CYCLES - 2);

  sched_state_t          state;
  logic [CW-1:0]         cnt;
  logic [NUM_OWNERS-1:0] pend;
  logic [NUM_OWNERS-1:0] take;
  logic [NUM_OWNERS-1:0] req_vec;
  logic [NUM_OWNERS-1:0] do_it_q;
  logic [NUM_OWNERS-1:0] done_q;
  logic                  tick;
  logic                  arb_point;
  sched_state_t          grant;
  logic [CW-1:0]         win_len;

  rtc_tick_gen #(
    .READ_PERIOD(READ_PERIOD)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .en   (en_lec),
    .tick (tick)
  );

  assign req_vec = {tick, req_esc, req_inic};

  for (genvar gi = 0; gi < NUM_OWNERS; gi++) begin : g_pend
    logic pend_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        pend_q <= (gi == OWN_INIC) ? POR_INIT : 1'b0;
      end else if ((gi == OWN_LEC) && !en_lec) begin
        pend_q <= 1'b0;
      end else begin
        pend_q <= (pend_q & ~take[gi]) | req_vec[gi];
      end
    end
    assign pend[gi] = pend_q;
  end

  always_comb begin
    grant = IDLE;
    if (pend[OWN_INIC]) begin
      grant = G_INIC;
    end else if (init_ok && pend[OWN_ESC]) begin
      grant = G_ESC;
    end else if (init_ok && pend[OWN_LEC]) begin
      grant = G_LEC;
    end
    arb_point = (state == IDLE) || ((state == GAP) && (cnt == GAP_ARB));
    take      = arb_point ? owner_mask(grant) : '0;

    win_len = '0;
    case (state)
      G_INIC:  win_len = CW'(INIC_CYCLES);
      G_ESC:   win_len = CW'(ESC_CYCLES);
      G_LEC:   win_len = CW'(LEC_CYCLES);
      default: win_len = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      do_it_q <= '0;
      done_q  <= '0;
      sel_bus <= SEL_NONE;
      busy    <= 1'b0;
      init_ok <= 1'b0;
    end else begin
      done_q <= '0;
      case (state)
        IDLE, GAP: begin
          if (arb_point) begin
            state <= grant;
            cnt   <= '0;
            busy  <= (grant != IDLE);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        G_INIC, G_ESC, G_LEC: begin
          if (cnt == win_len) begin
            state   <= GAP;
            cnt     <= '0;
            do_it_q <= '0;
            sel_bus <= SEL_NONE;
            done_q  <= owner_mask(state);
            if (state == G_INIC) begin
              init_ok <= 1'b1;
            end
          end else begin
            cnt     <= cnt + 1'b1;
            do_it_q <= owner_mask(state);
            sel_bus <= sel_code(state);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign do_it_inic = do_it_q[OWN_INIC];
  assign do_it_esc  = do_it_q[OWN_ESC];
  assign do_it_lec  = do_it_q[OWN_LEC];
  assign inic_done  = done_q[OWN_INIC];
  assign esc_done   = done_q[OWN_ESC];
  assign lec_done   = done_q[OWN_LEC];

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// Bench for rtc_access_scheduler: two instances (with and without power-on init)
// share the stimulus and are compared every cycle against a timeline model.
module tb_rtc_access_scheduler;

  localparam int WIN = 422;
  localparam int GAP = 8;
  localparam int PER = 100;

  logic clk = 1'b0;
  logic reset, req_inic, req_esc, en_lec;

  logic a_do_inic, a_do_esc, a_do_lec, a_busy, a_inic_done, a_esc_done, a_lec_done, a_init_ok;
  logic b_do_inic, b_do_esc, b_do_lec, b_busy, b_inic_done, b_esc_done, b_lec_done, b_init_ok;
  logic [1:0] a_sel, b_sel;

  always #5 clk = ~clk;

  rtc_access_scheduler #(
    .INIC_CYCLES(WIN), .ESC_CYCLES(WIN), .LEC_CYCLES(WIN),
    .GAP_CYCLES(GAP), .READ_PERIOD(PER), .POR_INIT(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset), .req_inic(req_inic), .req_esc(req_esc), .en_lec(en_lec),
    .do_it_inic(a_do_inic), .do_it_esc(a_do_esc), .do_it_lec(a_do_lec), .sel_bus(a_sel),
    .busy(a_busy), .inic_done(a_inic_done), .esc_done(a_esc_done), .lec_done(a_lec_done),
    .init_ok(a_init_ok)
  );

  rtc_access_scheduler #(
    .INIC_CYCLES(WIN), .ESC_CYCLES(WIN), .LEC_CYCLES(WIN),
    .GAP_CYCLES(GAP), .READ_PERIOD(PER), .POR_INIT(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .req_inic(req_inic), .req_esc(req_esc), .en_lec(en_lec),
    .do_it_inic(b_do_inic), .do_it_esc(b_do_esc), .do_it_lec(b_do_lec), .sel_bus(b_sel),
    .busy(b_busy), .inic_done(b_inic_done), .esc_done(b_esc_done), .lec_done(b_lec_done),
    .init_ok(b_init_ok)
  );

  int tests = 0;
  int fails = 0;

  // Timeline model: owner 0=inic 1=esc 2=lec, -1 none. A grant at edge g
  // means do_it over edges g+1..g+WIN, done at g+WIN+1, next arbitration g+WIN+GAP.
  longint e = 0;
  int     run_len = 0;
  bit     m_pend[2][3];
  bit     m_ok[2];
  int     m_owner[2] = '{-1, -1};
  longint m_g[2];
  longint m_next[2];

  // Monitors on dut_a
  logic   prev_on = 1'b0;
  bit     seen_fall = 1'b0;
  longint fall_e = 0;
  longint min_gap = 1000000;
  int     onehot_bad = 0;

  task automatic model_edge();
    bit tick;
    bit req[3];
    e++;
    if (reset) begin
      run_len = 0;
      for (int i = 0; i < 2; i++) begin
        m_pend[i][0] = (i == 0);
        m_pend[i][1] = 1'b0;
        m_pend[i][2] = 1'b0;
        m_ok[i]      = 1'b0;
        m_owner[i]   = -1;
      end
      return;
    end
    run_len = en_lec ? run_len + 1 : 0;
    tick = en_lec && (run_len % PER == 0);
    req  = '{req_inic, req_esc, tick};
    for (int i = 0; i < 2; i++) begin
      int grant;
      bit take[3];
      take  = '{1'b0, 1'b0, 1'b0};
      grant = -1;
      if (m_owner[i] < 0 || e == m_next[i]) begin
        if (m_pend[i][0]) grant = 0;
        else if (m_ok[i] && m_pend[i][1]) grant = 1;
        else if (m_ok[i] && m_pend[i][2]) grant = 2;
        m_owner[i] = grant;
        if (grant >= 0) begin
          take[grant] = 1'b1;
          m_g[i]      = e;
          m_next[i]   = e + WIN + GAP;
        end
      end
      if (m_owner[i] == 0 && e == m_g[i] + WIN + 1) m_ok[i] = 1'b1;
      for (int k = 0; k < 2; k++) m_pend[i][k] = (m_pend[i][k] & !take[k]) | req[k];
      m_pend[i][2] = en_lec & ((m_pend[i][2] & !take[2]) | tick);
    end
  endtask

  // {do_it inic,esc,lec, sel[1:0], busy, done inic,esc,lec, init_ok}
  function automatic bit [9:0] expv(input int i);
    bit [2:0] doit;
    bit [2:0] done;
    bit [1:0] sel;
    int o;
    doit = '0; done = '0; sel = '0;
    o = m_owner[i];
    if (o >= 0) begin
      if (e > m_g[i] && e <= m_g[i] + WIN) begin
        doit[2-o] = 1'b1;
        sel = 2'(o + 1);
      end
      if (e == m_g[i] + WIN + 1) done[2-o] = 1'b1;
    end
    return {doit, sel, (o >= 0), done, m_ok[i]};
  endfunction

  task automatic chk(input string tag, input longint obs, input longint expd);
    tests++;
    assert (obs === expd) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expd);
    end
  endtask

  task automatic check_cycle();
    logic [9:0] va, vb, xa, xb;
    logic a_on;
    va = {a_do_inic, a_do_esc, a_do_lec, a_sel, a_busy, a_inic_done, a_esc_done, a_lec_done, a_init_ok};
    vb = {b_do_inic, b_do_esc, b_do_lec, b_sel, b_busy, b_inic_done, b_esc_done, b_lec_done, b_init_ok};
    xa = expv(0);
    xb = expv(1);
    tests++;
    assert (va === xa) else begin
      fails++;
      $error("FAIL cycle_a edge %0d: observed %b, expected %b", e, va, xa);
    end
    tests++;
    assert (vb === xb) else begin
      fails++;
      $error("FAIL cycle_b edge %0d: observed %b, expected %b", e, vb, xb);
    end
    if ($countones({a_do_inic, a_do_esc, a_do_lec}) > 1) onehot_bad++;
    a_on = a_do_inic | a_do_esc | a_do_lec;
    if (reset) begin
      seen_fall = 1'b0;
    end else begin
      if (a_on && !prev_on && seen_fall && (e - fall_e) < min_gap) min_gap = e - fall_e;
      if (!a_on && prev_on) begin
        fall_e    = e;
        seen_fall = 1'b1;
      end
    end
    prev_on = a_on;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_cycle();
  endtask

  initial begin
    int n;
    int cnt_a, cnt_b;
    logic prev;
    reset = 1'b1; req_inic = 1'b0; req_esc = 1'b0; en_lec = 1'b0;
    repeat (3) step();
    chk("reset_busy", a_busy, 0);
    chk("reset_init_ok", a_init_ok, 0);

    // Power-on init on dut_a: latency, window length, done and init_ok
    reset = 1'b0;
    n = 0;
    while (!a_do_inic && n < 10) begin step(); n++; end
    chk("inic_latency", n, 2);
    chk("inic_sel", a_sel, 1);
    n = 0;
    while (a_do_inic && n < 1000) begin step(); n++; end
    chk("inic_len", n, WIN);
    chk("inic_done_pulse", a_inic_done, 1);
    chk("init_ok_set", a_init_ok, 1);
    chk("gap_sel", a_sel, 0);
    repeat (GAP) step();

    // No grants on dut_b without init, even with write and read requests
    req_esc = 1'b1; en_lec = 1'b1; step(); req_esc = 1'b0;
    cnt_b = 0;
    repeat (1000) begin step(); cnt_b += int'(b_busy); end
    chk("b_no_grant_before_init", cnt_b, 0);

    // Init on dut_b, three merged write pulses during it, then a write re-armed
    // on its own grant edge
    req_inic = 1'b1; step(); req_inic = 1'b0;
    n = 0;
    while (!b_do_inic && n < 50) begin step(); n++; end
    chk("b_inic_started", b_do_inic, 1);
    for (int k = 0; k < 3; k++) begin
      repeat (50) step();
      req_esc = 1'b1; step(); req_esc = 1'b0;
    end
    n = 0;
    while (e != m_next[1] - 1 && n < 1000) begin step(); n++; end
    chk("b_arb_wait_in_bound", int'(n < 1000), 1);
    req_esc = 1'b1; step(); req_esc = 1'b0;
    cnt_b = 0;
    repeat (1800) begin step(); cnt_b += int'(b_esc_done); end
    chk("b_esc_windows", cnt_b, 2);

    // Randomized traffic
    repeat (5000) begin
      req_esc  = ($urandom_range(0, 199) == 0);
      req_inic = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 699) == 0) en_lec = ~en_lec;
      step();
    end
    req_esc = 1'b0; req_inic = 1'b0; en_lec = 1'b0;
    repeat (1000) step();

    // Disabling reads mid-window lets the window finish and stops further reads
    en_lec = 1'b1;
    n = 0;
    while (!a_do_lec && n < 3000) begin step(); n++; end
    chk("a_lec_started", a_do_lec, 1);
    repeat (100) step();
    en_lec = 1'b0;
    cnt_a = 0; n = 0; prev = a_do_lec;
    repeat (1500) begin
      step();
      cnt_a += int'(a_lec_done);
      if (a_do_lec && !prev) n++;
      prev = a_do_lec;
    end
    chk("a_lec_done_after_disable", cnt_a, 1);
    chk("a_no_more_reads", n, 0);

    // Reset at cycle 200 of a write window, with another write pending
    req_esc = 1'b1; step(); req_esc = 1'b0;
    n = 0;
    while (!(m_owner[0] == 1 && e == m_g[0] + 100) && n < 2000) begin step(); n++; end
    req_esc = 1'b1; step(); req_esc = 1'b0;
    while (!(m_owner[0] == 1 && e == m_g[0] + 200) && n < 2000) begin step(); n++; end
    chk("esc_cycle200_reached", a_do_esc, 1);
    reset = 1'b1; step();
    chk("rst_do_it_esc", a_do_esc, 0);
    chk("rst_sel", a_sel, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_esc_done", a_esc_done, 0);
    reset = 1'b0;
    n = 0; prev = a_do_esc;
    repeat (1000) begin
      step();
      if (a_do_esc && !prev) n++;
      prev = a_do_esc;
    end
    chk("rst_clears_pend_esc", n, 0);

    chk("min_gap_between_windows", min_gap, GAP);
    chk("one_do_it_at_a_time", onehot_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
